// File: rtl/screen_arbiter.sv
// screen_arbiter: VGA/CPU/debug arbiter for the single-port Hack screen RAM (define SCREEN_ARB_RR_EN for CPU/debug round-robin)
module screen_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic                  vga_gnt,
  output logic                  vga_rvalid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  localparam int DEPTH = 1 + RD_LATENCY;
  localparam logic [1:0] OWN_VGA = 2'd0;
  localparam logic [1:0] OWN_CPU = 2'd1;
  localparam logic [1:0] OWN_DBG = 2'd2;

  logic                  cpu_win;
  logic [2:0]            tag_q [DEPTH];
  logic [2:0]            tag_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

`ifdef SCREEN_ARB_RR_EN
  logic ptr_q, ptr_d;
  assign cpu_win = !dbg_req || !ptr_q;
  assign ptr_d   = cpu_gnt ? 1'b1 : dbg_gnt ? 1'b0 : ptr_q;
  // pointer moves away from whichever of CPU/debug was just served (0 = CPU next)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
`else
  assign cpu_win = 1'b1;
`endif

  assign vga_gnt = vga_req;
  assign cpu_gnt = !vga_req && cpu_req && cpu_win;
  assign dbg_gnt = !vga_req && dbg_req && !cpu_gnt;

  // next RAM command and the read tag for this cycle's winner
  always_comb begin
    ram_en_d    = vga_gnt | cpu_gnt | dbg_gnt;
    ram_we_d    = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);
    ram_addr_d  = vga_gnt ? vga_addr : cpu_gnt ? cpu_addr : dbg_gnt ? dbg_addr : ram_addr_q;
    ram_wdata_d = cpu_gnt ? cpu_wdata : dbg_gnt ? dbg_wdata : ram_wdata_q;
    tag_d       = vga_gnt              ? {1'b1, OWN_VGA} :
                  (cpu_gnt && !cpu_we) ? {1'b1, OWN_CPU} :
                  (dbg_gnt && !dbg_we) ? {1'b1, OWN_DBG} : 3'b000;
  end

  // registered RAM command; address/data hold when idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end

  // tag shift register aligned with RAM read latency; reset drops in-flight reads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= 3'b000;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end

  assign vga_rvalid = tag_q[DEPTH-1] == {1'b1, OWN_VGA};
  assign cpu_rvalid = tag_q[DEPTH-1] == {1'b1, OWN_CPU};
  assign dbg_rvalid = tag_q[DEPTH-1] == {1'b1, OWN_DBG};
  assign rdata      = ram_rdata;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
endmodule

// File: tb/tb_screen_arbiter.sv
// tb_screen_arbiter: table, directed and randomized checks of screen_arbiter against a RAM model and a reference model
module tb_screen_arbiter;
  localparam int AW = 13;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vga_req, vga_gnt, vga_rvalid;
  logic [AW-1:0] vga_addr;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [2:0]    gnts, rvs;

  screen_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  assign gnts = {vga_gnt, cpu_gnt, dbg_gnt};
  assign rvs  = {vga_rvalid, cpu_rvalid, dbg_rvalid};

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a == 13'h0100) ? 16'hBEEF : ({3'b000, a} ^ 16'h5A5A);
  endfunction

  logic [DW-1:0]       ram_mem [1<<AW];
  bit   [(1<<AW)-1:0]  ram_written;
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr]     <= ram_wdata;
        ram_written[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= ram_written[ram_addr] ? ram_mem[ram_addr] : init_word(ram_addr);
      end
    end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vga_req = 0; vga_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  typedef struct {
    logic       v, c, d;
    logic [2:0] gnt;
  } vec_t;

  typedef struct {
    int            due;
    int            owner;
    logic [DW-1:0] data;
  } ret_t;

  vec_t          tbl [8];
  ret_t          retq [$];
  logic [DW-1:0] mm [int];
  logic [2:0]    rr_exp [4];

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return mm.exists(int'(a)) ? mm[int'(a)] : init_word(a);
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return AW'(13'h0200 + 13'($urandom_range(0, 31)));
  endfunction

  initial begin
    int            win;
    logic          prefer_dbg, cpu_hold, dbg_hold;
    logic          exp_en, exp_we, w_we;
    logic [AW-1:0] exp_addr, w_addr;
    logic [DW-1:0] exp_wdata, w_wdata, exp_rd;
    logic [2:0]    exp_g, exp_rv;
    ret_t          r;

    idle_inputs();
    tbl = '{'{1'b0, 1'b0, 1'b0, 3'b000}, '{1'b0, 1'b0, 1'b1, 3'b001},
            '{1'b0, 1'b1, 1'b0, 3'b010}, '{1'b0, 1'b1, 1'b1, 3'b010},
            '{1'b1, 1'b0, 1'b0, 3'b100}, '{1'b1, 1'b0, 1'b1, 3'b100},
            '{1'b1, 1'b1, 1'b0, 3'b100}, '{1'b1, 1'b1, 1'b1, 3'b100}};

    // grant priority table applied while reset holds the arbiter state
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      vga_req = tbl[i].v; cpu_req = tbl[i].c; dbg_req = tbl[i].d;
      vga_addr = 13'h0011; cpu_addr = 13'h0022; dbg_addr = 13'h0033;
      #2;
      chk($sformatf("tbl_gnt[%0d]", i), gnts, tbl[i].gnt);
      chk($sformatf("tbl_ramen[%0d]", i), ram_en, 1'b0);
      chk($sformatf("tbl_rv[%0d]", i), rvs, 3'b000);
    end
    idle_inputs();
    #1;
    chk("reset_cmd", {ram_en, ram_we, ram_addr, ram_wdata}, 64'd0);

    // reset release then idle
    next();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_outs", {gnts, rvs, ram_en, ram_we, ram_addr, ram_wdata}, 64'd0);
      next();
    end

    // single VGA read
    vga_req = 1; vga_addr = 13'h0100;
    @(negedge clk); chk("vga_gnt_c0", gnts, 3'b100);
    next(); vga_req = 0;
    @(negedge clk); chk("vga_cmd_c1", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 13'h0100});
    chk("vga_rv_c1", rvs, 3'b000);
    next();
    @(negedge clk); chk("vga_rv_c2", rvs, 3'b100); chk("vga_rdata_c2", rdata, 16'hBEEF);
    chk("vga_ramen_c2", ram_en, 1'b0);
    next(); next();

    // three-way contention
    vga_req = 1; vga_addr = 13'h0010;
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0020;
    dbg_req = 1; dbg_we = 0; dbg_addr = 13'h0030;
    @(negedge clk); chk("c3_gnt0", gnts, 3'b100);
    next(); vga_req = 0;
    @(negedge clk); chk("c3_gnt1", gnts, 3'b010); chk("c3_addr1", {ram_en, ram_addr}, {1'b1, 13'h0010});
    next(); cpu_req = 0;
    @(negedge clk); chk("c3_gnt2", gnts, 3'b001); chk("c3_addr2", {ram_en, ram_addr}, {1'b1, 13'h0020});
    chk("c3_rv2", rvs, 3'b100); chk("c3_rd2", rdata, init_word(13'h0010));
    next(); dbg_req = 0;
    @(negedge clk); chk("c3_gnt3", gnts, 3'b000); chk("c3_addr3", {ram_en, ram_addr}, {1'b1, 13'h0030});
    chk("c3_rv3", rvs, 3'b010); chk("c3_rd3", rdata, init_word(13'h0020));
    next();
    @(negedge clk); chk("c3_rv4", rvs, 3'b001); chk("c3_rd4", rdata, init_word(13'h0030));
    chk("c3_ramen4", ram_en, 1'b0);
    next(); next();

    // CPU write then debug read of the same word
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'h1FFF; cpu_wdata = 16'h1234;
    @(negedge clk); chk("wr_gnt0", gnts, 3'b010);
    next(); cpu_req = 0; cpu_we = 0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 13'h1FFF;
    @(negedge clk); chk("wr_gnt1", gnts, 3'b001);
    chk("wr_cmd1", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 13'h1FFF, 16'h1234});
    next(); dbg_req = 0;
    @(negedge clk); chk("wr_cmd2", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 13'h1FFF});
    chk("wr_rv2", rvs, 3'b000);
    next();
    @(negedge clk); chk("wr_rv3", rvs, 3'b001); chk("wr_rd3", rdata, 16'h1234);
    next();
    @(negedge clk); chk("wr_rv4", rvs, 3'b000);
    next();

    // reset the cycle after a CPU read grant
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0005;
    @(negedge clk); chk("rst_gnt0", gnts, 3'b010);
    next(); cpu_req = 0; rst_n = 0;
    @(negedge clk); chk("rst_ramen1", ram_en, 1'b0); chk("rst_rv1", rvs, 3'b000);
    next();
    @(negedge clk); chk("rst_rv2", rvs, 3'b000);
    next(); rst_n = 1;
    @(negedge clk); chk("rst_rv3", rvs, 3'b000);
    next();
    @(negedge clk); chk("rst_rv4", rvs, 3'b000);
    next();

    // CPU and debug contend for four cycles with VGA idle
`ifdef SCREEN_ARB_RR_EN
    rr_exp = '{3'b010, 3'b001, 3'b010, 3'b001};
`else
    rr_exp = '{3'b010, 3'b010, 3'b010, 3'b010};
`endif
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0040;
    dbg_req = 1; dbg_we = 0; dbg_addr = 13'h0041;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk($sformatf("rr_gnt[%0d]", i), gnts, rr_exp[i]);
      next();
    end
    idle_inputs();
    next(); next(); next();

    // randomized traffic against the reference model
    rst_n = 0;
    next(); next();
    rst_n = 1;
    prefer_dbg = 0; cpu_hold = 0; dbg_hold = 0;
    exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
    retq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      vga_req  = ($urandom_range(0, 2) == 0);
      vga_addr = rand_addr();
      if (!cpu_hold) begin
        cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = rand_addr(); cpu_wdata = DW'($urandom);
      end
      if (!dbg_hold) begin
        dbg_req = 1'($urandom_range(0, 1)); dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = rand_addr(); dbg_wdata = DW'($urandom);
      end
      @(negedge clk);
      win = vga_req ? 0 : (cpu_req && !(dbg_req && prefer_dbg)) ? 1 : dbg_req ? 2 : 3;
      exp_g = (win == 3) ? 3'b000 : 3'(3'b100 >> win);
      chk("rand_gnt", gnts, exp_g);
      chk("rand_cmd", {ram_en, ram_we, ram_addr}, {exp_en, exp_we, exp_addr});
      if (exp_we) chk("rand_wdata", ram_wdata, exp_wdata);
      exp_rv = 3'b000; exp_rd = '0;
      if (retq.size() > 0 && retq[0].due == cyc) begin
        r = retq.pop_front();
        exp_rv = 3'(3'b100 >> r.owner);
        exp_rd = r.data;
      end
      chk("rand_rvalid", rvs, exp_rv);
      if (exp_rv != 3'b000) chk("rand_rdata", rdata, exp_rd);
      w_we    = (win == 1) ? cpu_we : (win == 2) ? dbg_we : 1'b0;
      w_addr  = (win == 0) ? vga_addr : (win == 1) ? cpu_addr : dbg_addr;
      w_wdata = (win == 1) ? cpu_wdata : dbg_wdata;
      exp_en = (win != 3);
      exp_we = (win != 3) && w_we;
      if (win != 3) begin
        exp_addr = w_addr;
        if (win != 0) exp_wdata = w_wdata;
        if (w_we) mm[int'(w_addr)] = w_wdata;
        else retq.push_back('{cyc + 2, win, model_rd(w_addr)});
      end
`ifdef SCREEN_ARB_RR_EN
      if (win == 1) prefer_dbg = 1;
      else if (win == 2) prefer_dbg = 0;
`endif
      cpu_hold = cpu_req && (win != 1);
      dbg_hold = dbg_req && (win != 2);
      next();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/screen_arbiter.md
# screen_arbiter

Arbitrates the single-port Hack screen memory among three requesters inside `hack_top`:

- the VGA pixel fetcher, which is read-only and has a hard deadline;
- the Hack CPU memory-mapped screen port;
- the UART debug/loader port.

It issues at most one RAM access per cycle, registers the RAM command, and routes each read return back to its owner through a tag pipeline.

## Interface

Parameters:

- `ADDR_WIDTH`, default 13: screen word address width (8K words).
- `DATA_WIDTH`, default 16: screen word width.
- `RD_LATENCY`, default 1: RAM read latency in cycles, from a registered `ram_en` to valid `ram_rdata`. Legal values are 1 and 2.

Ports:

- `clk`  in  1: system clock, the VGA pixel clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `vga_req`  in  1: VGA read request.
- `vga_addr`  in  ADDR_WIDTH: VGA read address.
- `vga_gnt`  out  1: VGA request accepted this cycle.
- `vga_rvalid`  out  1: VGA read data valid.
- `cpu_req`, `cpu_we`  in  1: CPU request and write enable.
- `cpu_addr`  in  ADDR_WIDTH: CPU address.
- `cpu_wdata`  in  DATA_WIDTH: CPU write data.
- `cpu_gnt`, `cpu_rvalid`  out  1: CPU grant and read valid.
- `dbg_req`, `dbg_we`  in  1: debug request and write enable.
- `dbg_addr`  in  ADDR_WIDTH: debug address.
- `dbg_wdata`  in  DATA_WIDTH: debug write data.
- `dbg_gnt`, `dbg_rvalid`  out  1: debug grant and read valid.
- `rdata`  out  DATA_WIDTH: shared read data, meaningful only while one `*_rvalid` is high.
- `ram_en`, `ram_we`  out  1: registered RAM command.
- `ram_addr`  out  ADDR_WIDTH: registered RAM address.
- `ram_wdata`  out  DATA_WIDTH: registered RAM write data.
- `ram_rdata`  in  DATA_WIDTH: RAM read data.

## Operation

- Request handshake:
  - A requester asserts `*_req` and holds its address, write enable and write data stable until `*_gnt` is seen high.
  - `*_gnt` is combinational from the current requests and the arbiter state.
  - `*_req` may drop after the grant cycle or stay high for back-to-back access.
- Priority:
  - VGA always wins and is never stalled.
  - Between CPU and debug, fixed priority CPU > debug, unless round-robin is configured.
  - Exactly one `*_gnt` is high in any cycle in which any request is high.
- Command register:
  - In the cycle after a grant: `ram_en`=1, and `ram_we`/`ram_addr`/`ram_wdata` hold the winner's values.
  - `vga` grants always give `ram_we`=0.
  - With no grant: `ram_en`=0, `ram_we`=0, and address/data hold their previous values.
- Tag pipeline:
  - Depth 1+RD_LATENCY. Each entry holds {valid, owner[1:0]}.
  - An entry is pushed for every granted read and a bubble for writes and idle cycles.
  - At the pipeline output, the owner's `*_rvalid` pulses for one cycle.
  - `rdata` = `ram_rdata`, passed combinationally to all requesters.
- Writes produce no `rvalid`.
- Read-after-write to the same address from any requesters returns the new data. This holds by order, since commands reach the RAM in grant order.
- Reset mid-operation:
  - Clears all in-flight tags immediately.
  - Reads that were granted but not yet returned never produce `rvalid`. Requesters must re-issue them.

## Timing

- Reset values: `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, all `*_rvalid`=0, all tags invalid, round-robin pointer = CPU.
- `*_gnt` is 0 whenever its `*_req` is 0.
- Read latency: grant in cycle N gives `*_rvalid` in cycle N+1+RD_LATENCY (N+2 for the default).
- Throughput is one access per cycle. Sustained `vga_req` fully starves CPU and debug. The VGA fetcher leaves idle slots in blanking and in every other pixel slot.
- Simultaneous requests from all three: VGA granted, and the others keep waiting with their requests held.

## Configuration

- `SCREEN_ARB_RR_EN` defined:
  - Round-robin between CPU and debug.
  - A 1-bit pointer toggles to the other requester after each CPU or debug grant.
  - When only one of them is requesting, it wins regardless of the pointer.
  - VGA priority is unchanged.
- Undefined: fixed priority CPU > debug, and no pointer flop exists.

## Test plan

- Reset, then idle:
  - During reset and afterwards with all `req`=0: every output is 0 and `ram_en` is never asserted.
- VGA read, RD_LATENCY=1:
  - `vga_req`=1, `vga_addr`=0x0100 in cycle 0, with the RAM model returning 0xBEEF.
  - Required: `vga_gnt`=1 in cycle 0; `ram_en`=1 and `ram_addr`=0x0100 in cycle 1; `vga_rvalid`=1 and `rdata`=0xBEEF in cycle 2.
- Three-way contention:
  - All requesters assert in the same cycle with addresses 0x10/0x20/0x30, VGA for one cycle only.
  - Required: grants in the order VGA, CPU, debug on consecutive cycles; `ram_addr` sequence 0x10, 0x20, 0x30; `rvalid` pulses return to their owners in the same order.
- Write then read:
  - CPU writes 0x1234 to 0x1FFF; debug then reads 0x1FFF.
  - Required: `dbg_rvalid` with `rdata`=0x1234, and no `cpu_rvalid` pulse.
- Reset mid-flight:
  - Assert `rst_n`=0 the cycle after a CPU read grant.
  - Required: no `cpu_rvalid` during or after reset, and `ram_en`=0 immediately.
- Round-robin, with `SCREEN_ARB_RR_EN` defined:
  - CPU and debug both hold `req` for 4 cycles with VGA idle.
  - Required: grants CPU, debug, CPU, debug.
  - Without the macro, the same stimulus gives CPU on all 4 cycles.
